keypad_encoder: RTL and testbench
=================================

Name: keypad_encoder

Overview:
- Scans a 4x4 matrix keypad and encodes the pressed key into a 4-bit code; the sequential counterpart of the team's 3x8/4x16 decoders.
- Drives active-low one-hot row strobes and reads active-low column returns.
- Debounces the press and hands the code to downstream logic over a valid/ready handshake.
- Downstream logic is typically the 7-segment display path.

Parameters:
SCAN_DIV, 4, clock cycles each row strobe is held; legal range is 3 or more (row settle plus 2-flop synchronizer).
DEBOUNCE, 3, consecutive identical scan frames required to accept a press or a release; legal range is 2 or more.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
row_l  output  4  active-low one-hot row strobe; row_l[r]=0 selects row r.
col_l  input  4  active-low column returns, asynchronous to clk.
code  output  4  key index = row*4 + col.
valid  output  1  code is available.
ready  input  1  consumer accepts code when valid and ready are both 1.
overrun  output  1  sticky flag: a debounced press was dropped because valid was still pending.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values:
  - row_l=4'b1110, code=0, valid=0, overrun=0.
  - Slot counter=0, row index=0, FSM in S_IDLE, candidate=0, stable count=0, synchronizer flops=4'b1111.
- Scan:
  - Slot counter runs 0..SCAN_DIV-1, then the row index advances 0..3 and wraps.
  - row_l = ~(1<<row). One frame = 4*SCAN_DIV cycles.
- col_l passes through a 2-flop synchronizer.
- On the last cycle of each row slot, the synchronized columns are sampled into a frame accumulator.
- Encoding: within a frame, the lowest key index pressed wins; the frame result is {hit, idx}. The accumulator clears at frame start.
- The FSM evaluates once per frame, on the last cycle of row 3 (cnt is the stable count):
  - S_IDLE: no hit -> stay. Hit -> cand=idx, cnt=1, go to S_PRESS.
  - S_PRESS, hit with idx==cand: cnt+1. When cnt reaches DEBOUNCE -> emit cand, go to S_HELD.
  - S_PRESS, hit with idx!=cand: cand=idx, cnt=1.
  - S_PRESS, no hit: go to S_IDLE.
  - S_HELD, hit (any idx): stay. No auto-repeat; a key change while held is ignored.
  - S_HELD, no hit: cnt=1, go to S_REL.
  - S_REL, no hit: cnt+1. When cnt reaches DEBOUNCE -> go to S_IDLE.
  - S_REL, hit: go to S_HELD.
- Emit:
  - If valid=0: code<=cand and valid<=1 on the clock edge ending the evaluation cycle.
  - If valid=1: code and valid are unchanged, overrun<=1, and the press is discarded. The FSM still moves to S_HELD.
- Handshake:
  - code is held stable while valid=1.
  - valid and ready both 1 at a rising edge -> valid<=0 on that edge.
  - An emit and a transfer in the same cycle both take effect: valid stays 1 and code takes the new value.
- overrun clears only on reset.
- Latency: a press stable from frame F onward sets valid one cycle after the evaluation of frame F+DEBOUNCE-1.
- Column changes mid-frame: only the per-row sample instants matter.
- Reset asserted mid-scan or mid-debounce: asynchronous return to reset values. No pending candidate survives.

Test Plan:
- Reset, col_l=4'hF -> row_l sequence 1110, 1101, 1011, 0111, each held 4 cycles, repeating; valid=0, code=0, overrun=0.
- Key 6 held (col_l[2]=0 while row_l=1101), ready=1 -> code=4'h6 with valid high for exactly 1 cycle, one cycle after the 3rd complete frame containing the key. No further valid while the key is held.
- Key 9 for 2 frames, absent 1 frame, present 3 frames -> exactly one report, code=4'h9, after the final 3rd frame.
- Keys 3 and 12 pressed together -> code=4'h3.
- ready=0: key 5 reported, then released for 3 frames, then key A held 3 frames -> valid stays 1, code stays 5, overrun=1. Raising ready -> valid=0 the next cycle, overrun stays 1.
- rst_n pulsed low while in S_PRESS with cand=7 -> all outputs return to reset values immediately. With the key released after reset, no report occurs, and scanning restarts at row_l=1110.

Source files
------------

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: strobes rows, synchronizes and debounces column
// returns, and delivers the lowest pressed key index over a valid/ready handshake.
module keypad_encoder #(
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] row_l,
   input  logic [3:0] col_l,
   output logic [3:0] code,
   output logic       valid,
   input  logic       ready,
   output logic       overrun
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRESS = 2'd1,
      S_HELD  = 2'd2,
      S_REL   = 2'd3
   } state_t;

   // Lowest-numbered asserted column of an active-high press vector.
   function automatic logic [1:0] low_col(input logic [3:0] p);
      logic [1:0] c;
      if (p[0]) begin
         c = 2'd0;
      end else if (p[1]) begin
         c = 2'd1;
      end else if (p[2]) begin
         c = 2'd2;
      end else begin
         c = 2'd3;
      end
      return c;
   endfunction

   logic [SW-1:0] slot_q, slot_d;
   logic [1:0]    row_q, row_d;
   logic [3:0]    row_l_q, row_l_d;
   logic [3:0]    sync1_q, sync1_d;
   logic [3:0]    sync2_q, sync2_d;
   logic          acc_hit_q, acc_hit_d;
   logic [3:0]    acc_idx_q, acc_idx_d;
   state_t        state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          overrun_q, overrun_d;

   logic          slot_last_s;
   logic          eval_s;
   logic [3:0]    pressed_s;
   logic          row_hit_s;
   logic [3:0]    row_idx_s;
   logic          frame_hit_s;
   logic [3:0]    frame_idx_s;
   logic [CW-1:0] cnt_inc_s;
   logic          emit_s;

   assign slot_last_s = (slot_q == SLOT_LAST);
   assign eval_s      = slot_last_s && (row_q == 2'd3);
   assign pressed_s   = ~sync2_q;
   assign row_hit_s   = (pressed_s != 4'b0000);
   assign row_idx_s   = {row_q, low_col(pressed_s)};
   assign cnt_inc_s   = cnt_q + CW'(1);

   // Rows are visited in ascending order, so the first hit in a frame is the lowest index.
   assign frame_hit_s = acc_hit_q || row_hit_s;
   assign frame_idx_s = acc_hit_q ? acc_idx_q : row_idx_s;

   // Row-slot timing and registered one-hot row strobe.
   always_comb begin
      slot_d   = slot_q;
      row_d    = row_q;
      if (slot_last_s) begin
         slot_d = {SW{1'b0}};
         row_d  = row_q + 2'd1;
      end else begin
         slot_d = slot_q + SW'(1);
         row_d  = row_q;
      end
      row_l_d  = ~(4'b0001 << row_d);
      sync1_d  = col_l;
      sync2_d  = sync1_q;
   end

   // Frame accumulator: latched at each row's last slot, cleared when the frame is evaluated.
   always_comb begin
      acc_hit_d = acc_hit_q;
      acc_idx_d = acc_idx_q;
      if (eval_s) begin
         acc_hit_d = 1'b0;
         acc_idx_d = 4'h0;
      end else if (slot_last_s && !acc_hit_q && row_hit_s) begin
         acc_hit_d = 1'b1;
         acc_idx_d = row_idx_s;
      end else begin
         acc_hit_d = acc_hit_q;
         acc_idx_d = acc_idx_q;
      end
   end

   // Debounce FSM, stepped once per frame.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      emit_s  = 1'b0;
      if (eval_s) begin
         case (state_q)
            S_IDLE: begin
               if (frame_hit_s) begin
                  cand_d  = frame_idx_s;
                  cnt_d   = CNT_ONE;
                  state_d = S_PRESS;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_PRESS: begin
               if (!frame_hit_s) begin
                  state_d = S_IDLE;
               end else if (frame_idx_s != cand_q) begin
                  cand_d = frame_idx_s;
                  cnt_d  = CNT_ONE;
               end else if (cnt_inc_s == CNT_DONE) begin
                  cnt_d   = cnt_inc_s;
                  emit_s  = 1'b1;
                  state_d = S_HELD;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            S_HELD: begin
               if (!frame_hit_s) begin
                  cnt_d   = CNT_ONE;
                  state_d = S_REL;
               end else begin
                  state_d = S_HELD;
               end
            end
            S_REL: begin
               if (frame_hit_s) begin
                  state_d = S_HELD;
               end else if (cnt_inc_s == CNT_DONE) begin
                  cnt_d   = cnt_inc_s;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Handshake: an emit coinciding with a transfer replaces the code; otherwise a pending code wins.
   always_comb begin
      code_d    = code_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (emit_s) begin
         if (!valid_q || ready) begin
            code_d  = cand_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q    <= {SW{1'b0}};
         row_q     <= 2'd0;
         row_l_q   <= 4'b1110;
         sync1_q   <= 4'b1111;
         sync2_q   <= 4'b1111;
         acc_hit_q <= 1'b0;
         acc_idx_q <= 4'h0;
         state_q   <= S_IDLE;
         cand_q    <= 4'h0;
         cnt_q     <= {CW{1'b0}};
         code_q    <= 4'h0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         row_q     <= row_d;
         row_l_q   <= row_l_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         acc_hit_q <= acc_hit_d;
         acc_idx_q <= acc_idx_d;
         state_q   <= state_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign row_l   = row_l_q;
   assign code    = code_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: a behavioural keypad drives col_l from row_l
// and a 16-bit pressed-key mask; valid pulses are recorded and checked.
module tb_keypad_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] row_l;
   logic [3:0] col_l;
   logic [3:0] code;
   logic       valid;
   logic       ready = 1'b1;
   logic       overrun;

   logic [15:0] keys = 16'h0000;
   int          cyc;
   int          n_valid;
   int          first_cyc;
   logic [3:0]  last_code;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      string      name;
      logic [15:0] keys;
      int         frames;
      int         exp_count;
      logic [3:0] exp_code;
      int         exp_first;
   } vec_t;

   vec_t vecs[6];

   keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .row_l   (row_l),
      .col_l   (col_l),
      .code    (code),
      .valid   (valid),
      .ready   (ready),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   // Matrix model: a pressed key connects its row strobe to its column return.
   always_comb begin
      col_l = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row_l[r] && keys[r*4 + c]) col_l[c] = 1'b0;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         n_valid   = 0;
         first_cyc = -1;
         last_code = 4'h0;
      end else if (valid) begin
         if (n_valid == 0) first_cyc = cyc;
         n_valid   = n_valid + 1;
         last_code = code;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vecs[0] = '{"no_key",    16'h0000,      6, 0, 4'h0, -1};
      vecs[1] = '{"key6",      16'h0040,      8, 1, 4'h6, 48};
      vecs[2] = '{"key3_12",   16'h1008,      8, 1, 4'h3, 48};
      vecs[3] = '{"key0",      16'h0001,      6, 1, 4'h0, 48};
      vecs[4] = '{"key15",     16'h8000,      6, 1, 4'hF, 48};
      vecs[5] = '{"key5_6",    16'h0060,      6, 1, 4'h5, 48};

      // Reset state and idle row sequence.
      keys = 16'h0000;
      ready = 1'b1;
      do_reset();
      check("rst_row_l", int'(row_l), 4'he);
      check("rst_valid", int'(valid), 0);
      check("rst_code", int'(code), 0);
      check("rst_overrun", int'(overrun), 0);
      for (int n = 1; n <= 32; n++) begin
         logic [3:0] exp_row;
         @(posedge clk);
         #1;
         exp_row = ~(4'b0001 << ((cyc / 4) % 4));
         check("scan_row_l", int'(row_l), int'(exp_row));
      end
      check("idle_no_valid", n_valid, 0);

      // Table-driven single-press vectors, key held from frame 0.
      for (int i = 0; i < 6; i++) begin
         keys = vecs[i].keys;
         ready = 1'b1;
         do_reset();
         wait_cyc(16 * vecs[i].frames);
         check({vecs[i].name, "_count"}, n_valid, vecs[i].exp_count);
         check({vecs[i].name, "_code"}, int'(last_code), int'(vecs[i].exp_code));
         check({vecs[i].name, "_first"}, first_cyc, vecs[i].exp_first);
         check({vecs[i].name, "_overrun"}, int'(overrun), 0);
      end

      // Key 9: two frames, one gap frame, then three frames.
      keys = 16'h0200;
      ready = 1'b1;
      do_reset();
      wait_cyc(32);
      keys = 16'h0000;
      wait_cyc(48);
      keys = 16'h0200;
      wait_cyc(160);
      check("bounce9_count", n_valid, 1);
      check("bounce9_code", int'(last_code), 9);
      check("bounce9_first", first_cyc, 96);

      // Overrun: ready low, key 5 reported, released, then key A.
      keys = 16'h0020;
      ready = 1'b0;
      do_reset();
      wait_cyc(47);
      check("ovr_valid_before", int'(valid), 0);
      wait_cyc(48);
      check("ovr_valid_at48", int'(valid), 1);
      check("ovr_code_at48", int'(code), 5);
      keys = 16'h0000;
      wait_cyc(96);
      keys = 16'h0400;
      wait_cyc(140);
      check("ovr_flag_early", int'(overrun), 0);
      wait_cyc(150);
      check("ovr_flag", int'(overrun), 1);
      check("ovr_valid_held", int'(valid), 1);
      check("ovr_code_held", int'(code), 5);
      ready = 1'b1;
      wait_cyc(151);
      check("ovr_valid_drop", int'(valid), 0);
      check("ovr_flag_sticky", int'(overrun), 1);
      wait_cyc(200);
      check("ovr_no_repeat", int'(valid), 0);

      // Reset while debouncing key 7 after an earlier report of key 6.
      keys = 16'h0040;
      ready = 1'b0;
      do_reset();
      wait_cyc(48);
      keys = 16'h0000;
      wait_cyc(96);
      keys = 16'h0080;
      wait_cyc(120);
      check("pre_rst_code", int'(code), 6);
      rst_n = 1'b0;
      #1;
      check("mid_rst_row_l", int'(row_l), 4'he);
      check("mid_rst_valid", int'(valid), 0);
      check("mid_rst_code", int'(code), 0);
      check("mid_rst_overrun", int'(overrun), 0);
      keys = 16'h0000;
      ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("post_rst_row_l", int'(row_l), 4'he);
      wait_cyc(32);
      check("post_rst_no_report", n_valid, 0);
      keys = 16'h0080;
      wait_cyc(96);
      check("post_rst_count", n_valid, 1);
      check("post_rst_code", int'(last_code), 7);
      check("post_rst_first", first_cyc, 80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
